// File: rtl/idu_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : idu_alu_issue
//  Purpose  : RV32I ALU-class decode plus issue buffer toward the ALU.
//             Define ALU_ISSUE_SKID_EN for a registered-ready two-entry skid
//             buffer; otherwise a single pipeline register is used.
//  Revision : 1.0 - initial release
// ============================================================================
module idu_alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [4:0]  rd,
    output logic        rd_wen,
    output logic        illegal
);

    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;
    localparam logic [3:0] c_ALU_ADD   = 4'b0000;
    localparam logic [3:0] c_ALU_PASS  = 4'b1111;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } entry_t;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_alt;
    logic       w_f7_ok;
    logic       w_shift;
    logic       w_imm_ok;
    entry_t     w_dec;
    logic       w_unused;

    assign w_opcode = inst[6:0];
    assign w_funct3 = inst[14:12];
    assign w_funct7 = inst[31:25];
    assign w_alt    = (w_funct7 == c_F7_ALT);
    assign w_f7_ok  = (w_funct7 == 7'd0) || w_alt;
    assign w_shift  = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
    assign w_imm_ok = (w_funct3 == 3'b001) ? (w_funct7 == 7'd0) :
                      (w_funct3 == 3'b101) ? w_f7_ok : 1'b1;
    // rs1 index is resolved by the register file before this stage
    assign w_unused = ^inst[19:15];

    always_comb begin
        w_dec.op  = c_ALU_PASS;
        w_dec.d1  = 32'd0;
        w_dec.d2  = 32'd0;
        w_dec.rd  = 5'd0;
        w_dec.wen = 1'b0;
        w_dec.ill = 1'b1;
        case (w_opcode)
            c_OPC_OP: begin
                if ((w_funct7 == 7'd0) ||
                    (w_alt && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))) begin
                    w_dec.op  = {w_funct3, w_alt};
                    w_dec.d1  = rs1_data;
                    w_dec.d2  = rs2_data;
                    w_dec.ill = 1'b0;
                end
            end
            c_OPC_IMM: begin
                if (w_imm_ok) begin
                    w_dec.op  = {w_funct3, (w_funct3 == 3'b101) && w_alt};
                    w_dec.d1  = rs1_data;
                    w_dec.d2  = w_shift ? {27'd0, inst[24:20]}
                                        : {{20{inst[31]}}, inst[31:20]};
                    w_dec.ill = 1'b0;
                end
            end
            c_OPC_LUI: begin
                w_dec.op  = c_ALU_PASS;
                w_dec.d2  = {inst[31:12], 12'd0};
                w_dec.ill = 1'b0;
            end
            c_OPC_AUIPC: begin
                w_dec.op  = c_ALU_ADD;
                w_dec.d1  = pc;
                w_dec.d2  = {inst[31:12], 12'd0};
                w_dec.ill = 1'b0;
            end
            default: ;
        endcase
        if (!w_dec.ill) begin
            w_dec.rd  = inst[11:7];
            w_dec.wen = |inst[11:7];
        end
    end

    entry_t r_head;
    logic   w_out_valid;
    logic   w_in_ready;
    logic   w_in_xfer;
    logic   w_out_xfer;

`ifdef ALU_ISSUE_SKID_EN
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_in_ready;
    entry_t     r_tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != c_FULL);
        end
    end

    always_comb begin
        w_in_xfer   = in_valid & r_in_ready;
        w_out_xfer  = w_out_valid & out_ready;
        w_state_nxt = r_state;
        case (r_state)
            c_EMPTY: if (w_in_xfer) w_state_nxt = c_ONE;
            c_ONE: begin
                if (w_in_xfer && !w_out_xfer)      w_state_nxt = c_FULL;
                else if (w_out_xfer && !w_in_xfer) w_state_nxt = c_EMPTY;
            end
            c_FULL:  if (w_out_xfer) w_state_nxt = c_ONE;
            default: w_state_nxt = c_EMPTY;
        endcase
    end

    always_comb begin
        w_out_valid = (r_state != c_EMPTY);
        w_in_ready  = r_in_ready;
    end

    // head is always the oldest entry; tail only fills while head is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                c_EMPTY: if (w_in_xfer) r_head <= w_dec;
                c_ONE: begin
                    if (w_in_xfer && w_out_xfer) r_head <= w_dec;
                    else if (w_in_xfer)          r_tail <= w_dec;
                end
                c_FULL:  if (w_out_xfer) r_head <= r_tail;
                default: ;
            endcase
        end
    end
`else
    logic r_valid;

    assign w_out_valid = r_valid;
    assign w_in_ready  = ~r_valid | out_ready;
    assign w_in_xfer   = in_valid & w_in_ready;
    assign w_out_xfer  = r_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_head  <= '0;
        end else if (w_in_xfer) begin
            r_valid <= 1'b1;
            r_head  <= w_dec;
        end else if (w_out_xfer) begin
            r_valid <= 1'b0;
        end
    end
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign alu_op    = r_head.op;
    assign alu_data1 = r_head.d1;
    assign alu_data2 = r_head.d2;
    assign rd        = r_head.rd;
    assign rd_wen    = r_head.wen;
    assign illegal   = r_head.ill;

endmodule
`default_nettype wire

// File: tb/tb_idu_alu_issue.sv
`default_nettype none
// Directed bench for idu_alu_issue: expected entries are queued on input
// acceptance and compared in order as the block hands them to the ALU.
module tb_idu_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_op;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        illegal;

    idu_alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .alu_data1 (alu_data1),
        .alu_data2 (alu_data2),
        .rd        (rd),
        .rd_wen    (rd_wen),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
        logic        chk_rd;
    } exp_t;

    exp_t        q[$];
    exp_t        pend;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_out = 0;
    int          stall = 0;
    int          snap;
    bit          accepted;
    bit          have_prev = 1'b0;
    logic [3:0]  p_op;
    logic [31:0] p_d1;
    logic [31:0] p_d2;
    logic [4:0]  p_rd;
    logic        p_wen;
    logic        p_ill;

    function automatic exp_t mk(input logic [3:0] op, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [4:0] r,
                                input logic wen, input logic ill);
        exp_t e;
        e.op = op; e.d1 = d1; e.d2 = d2; e.rd = r;
        e.wen = wen; e.ill = ill; e.chk_rd = !ill;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One clock: sample at the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (rst_n) begin
            if (have_prev) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_op", {28'd0, alu_op}, {28'd0, p_op});
                check("hold_d1", alu_data1, p_d1);
                check("hold_d2", alu_data2, p_d2);
                check("hold_rd", {27'd0, rd}, {27'd0, p_rd});
                check("hold_flags", {30'd0, rd_wen, illegal}, {30'd0, p_wen, p_ill});
            end
            have_prev = 1'b0;
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check("unexpected_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("out_op", {28'd0, alu_op}, {28'd0, e.op});
                    check("out_data1", alu_data1, e.d1);
                    check("out_data2", alu_data2, e.d2);
                    check("out_rd_wen", {31'd0, rd_wen}, {31'd0, e.wen});
                    check("out_illegal", {31'd0, illegal}, {31'd0, e.ill});
                    if (e.chk_rd) check("out_rd", {27'd0, rd}, {27'd0, e.rd});
                end
            end else if (out_valid) begin
                have_prev = 1'b1;
                p_op = alu_op; p_d1 = alu_data1; p_d2 = alu_data2;
                p_rd = rd; p_wen = rd_wen; p_ill = illegal;
            end
            if (in_valid && in_ready) begin
                q.push_back(pend);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (stall > 0) stall--;
        out_ready = (stall == 0);
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b, input exp_t e);
        inst = i; pc = p; rs1_data = a; rs2_data = b;
        pend = e;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (accepted) return;
        end
        check("accept_timeout", {31'd0, accepted}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_data1", alu_data1, 32'd0);
        check("rst_data2", alu_data2, 32'd0);
        check("rst_rd", {27'd0, rd}, 32'd0);
        check("rst_rd_wen", {31'd0, rd_wen}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
`ifdef ALU_ISSUE_SKID_EN
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
`else
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
`ifdef ALU_ISSUE_SKID_EN
        check("release_in_ready", {31'd0, in_ready}, 32'd0);
        cycle();
        check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
`else
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
`endif

        // sub x3,x1,x2 with one-cycle latency check
        send(32'h402081B3, 32'h0, 32'd5, 32'd7, mk(4'b0001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
        in_valid = 1'b0;
        check("latency_out_valid", {31'd0, out_valid}, 32'd1);
        idle(2);

        send(32'h40335293, 32'h0, 32'h80000000, 32'h0,
             mk(4'b1011, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0));
        send(32'h123450B7, 32'h0, 32'h0, 32'h0,
             mk(4'b1111, 32'h0, 32'h12345000, 5'd1, 1'b1, 1'b0));
        send(32'h00001117, 32'h80000000, 32'h0, 32'h0,
             mk(4'b0000, 32'h80000000, 32'h00001000, 5'd2, 1'b1, 1'b0));
        send(32'h0000007F, 32'h0, 32'h1, 32'h2, mk(4'b1111, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
        send(32'hFFF00213, 32'h0, 32'h11, 32'h0,
             mk(4'b0000, 32'h11, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0));
        send(32'h02208133, 32'h0, 32'h3, 32'h4, mk(4'b1111, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
        send(32'h40109093, 32'h0, 32'h3, 32'h4, mk(4'b1111, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
        send(32'h009473B3, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0,
             mk(4'b1110, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd7, 1'b1, 1'b0));
        send(32'h00208033, 32'h0, 32'h9, 32'hA, mk(4'b0000, 32'h9, 32'hA, 5'd0, 1'b0, 1'b0));
        idle(3);

        // four back-to-back instructions against a three-cycle stall
        stall = 3;
        out_ready = 1'b0;
        send(32'h00C5C533, 32'h0, 32'hAAAA5555, 32'h12345678,
             mk(4'b1000, 32'hAAAA5555, 32'h12345678, 5'd10, 1'b1, 1'b0));
`ifndef ALU_ISSUE_SKID_EN
        check("stall_in_ready_one", {31'd0, in_ready}, 32'd0);
`endif
        send(32'h0083B333, 32'h0, 32'd1, 32'hFFFFFFFF,
             mk(4'b0110, 32'd1, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0));
`ifdef ALU_ISSUE_SKID_EN
        check("stall_in_ready_two", {31'd0, in_ready}, 32'd0);
`endif
        send(32'h7FF4E493, 32'h0, 32'h100, 32'h0,
             mk(4'b1100, 32'h100, 32'h000007FF, 5'd9, 1'b1, 1'b0));
        send(32'h01F45413, 32'h0, 32'h80000001, 32'h0,
             mk(4'b1010, 32'h80000001, 32'd31, 5'd8, 1'b1, 1'b0));
        idle(6);
        check("drain_queue_empty", q.size(), 32'd0);

        // reset pulse while an entry is held
        stall = 1000;
        out_ready = 1'b0;
        send(32'h009473B3, 32'h0, 32'h1, 32'h3, mk(4'b1110, 32'h1, 32'h3, 5'd7, 1'b1, 1'b0));
        in_valid = 1'b0;
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        have_prev = 1'b0;
        q.delete();
        #1;
        check("async_reset_valid", {31'd0, out_valid}, 32'd0);
        check("async_reset_op", {28'd0, alu_op}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall = 0;
        out_ready = 1'b1;
        snap = n_out;
        idle(5);
        check("no_ghost_output", n_out - snap, 32'd0);
        check("post_reset_valid", {31'd0, out_valid}, 32'd0);

        send(32'hFFF00213, 32'h0, 32'h0, 32'h0, mk(4'b0000, 32'h0, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0));
        idle(3);
        check("final_queue_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
